cache_assoc_ctrl: RTL

Parametrised N-way set-associative, write-back, write-allocate cache controller with multi-word lines. It replaces the single-line fsm/mem pair.
- CPU side: valid/ready request channel plus a one-cycle response strobe.
- Memory side: valid/ready request channel plus a read-data beat strobe, so main-memory latency is arbitrary.
- Tag, valid and dirty state, data array and round-robin victim pointers all live inside the block.

---
 rtl/cache_assoc_pkg.sv | 34 +++
 rtl/cache_victim_sel.sv | 35 +++
 rtl/cache_assoc_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cache_assoc_pkg.sv
// cache_assoc_pkg: state encoding and address-field helpers for cache_assoc_ctrl.
package cache_assoc_pkg;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    function automatic int off_bits(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int aw, input int wpl, input int sets);
        return aw - 2 - off_bits(wpl) - idx_bits(sets);
    endfunction

    function automatic int way_bits(input int ways);
        return ways > 1 ? $clog2(ways) : 1;
    endfunction

    function automatic logic [63:0] addr_off(input logic [63:0] a, input int wpl);
        return (a >> 2) & 64'(wpl - 1);
    endfunction

    function automatic logic [63:0] addr_idx(input logic [63:0] a, input int wpl, input int sets);
        return (a >> (2 + off_bits(wpl))) & 64'(sets - 1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int wpl, input int sets);
        return a >> (2 + off_bits(wpl) + idx_bits(sets));
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: per-set round-robin pointers and lowest-invalid-way victim choice.
module cache_victim_sel
    import cache_assoc_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [idx_bits(SETS)-1:0]     set_idx,
    input  logic [WAYS-1:0]               valid_set,
    input  logic                          advance,
    output logic [way_bits(WAYS)-1:0]     victim
);

    localparam int WW = way_bits(WAYS);

    logic [WW-1:0] ptr [SETS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        end else if (advance) begin
            ptr[set_idx] <= WW'((int'(ptr[set_idx]) + 1) % WAYS);
        end
    end

    // an invalid way always beats the pointer; lowest index first
    always_comb begin
        victim = ptr[set_idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_set[w]) victim = WW'(w);
    end

endmodule

// File: rtl/cache_assoc_ctrl.sv
// cache_assoc_ctrl: N-way set-associative write-back/write-allocate cache controller.
// Define CACHE_PERF_CNT_EN to add hit_count/miss_count/wb_count outputs.
module cache_assoc_ctrl
    import cache_assoc_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WAYS           = 2,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req_valid,
    output logic                     cpu_req_ready,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_hit,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
`ifdef CACHE_PERF_CNT_EN
    input  logic                     mem_rdata_valid,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
    output logic [31:0]              wb_count
`else
    input  logic                     mem_rdata_valid
`endif
);

    localparam int OFF = off_bits(WORDS_PER_LINE);
    localparam int IDX = idx_bits(SETS);
    localparam int TAG = tag_bits(ADDRESS_WIDTH, WORDS_PER_LINE, SETS);
    localparam int OW  = OFF > 0 ? OFF : 1;
    localparam int WW  = way_bits(WAYS);
    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ~ADDRESS_WIDTH'(WORDS_PER_LINE * 4 - 1);

    state_t                  state;
    logic [ADDRESS_WIDTH-1:0] req_addr, victim_base;
    logic                    req_write, hit, hit_q, last_beat, refill_beat, advance;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [WW-1:0]           way_q, hit_way, victim;
    logic [OW-1:0]           beat, nxt_beat, req_off;
    logic [IDX-1:0]          req_idx;
    logic [TAG-1:0]          req_tag;
    logic [TAG-1:0]          tags   [WAYS][SETS];
    logic [DATA_WIDTH-1:0]   data_q [WAYS][SETS][WORDS_PER_LINE];
    logic [WAYS-1:0]         valid_q [SETS];
    logic [WAYS-1:0]         dirty_q [SETS];

    assign req_tag     = TAG'(addr_tag(64'(req_addr), WORDS_PER_LINE, SETS));
    assign req_idx     = IDX'(addr_idx(64'(req_addr), WORDS_PER_LINE, SETS));
    assign req_off     = OW'(addr_off(64'(req_addr), WORDS_PER_LINE));
    assign nxt_beat    = beat + OW'(1);
    assign last_beat   = beat == OW'(WORDS_PER_LINE - 1);
    // mem_req_valid low inside REFILL marks the data phase
    assign refill_beat = state == REFILL && !mem_req_valid && mem_rdata_valid;
    assign advance     = refill_beat && last_beat;
    assign victim_base = ADDRESS_WIDTH'({tags[victim][req_idx], req_idx}) << (OFF + 2);
    assign cpu_req_ready = reset && state == IDLE;

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (valid_q[req_idx][w] && tags[w][req_idx] == req_tag) begin
                hit = 1'b1;
                hit_way = WW'(w);
            end
    end

    cache_victim_sel #(.WAYS(WAYS), .SETS(SETS)) u_victim_sel (
        .clk      (clk),
        .reset    (reset),
        .set_idx  (req_idx),
        .valid_set(valid_q[req_idx]),
        .advance  (advance),
        .victim   (victim)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            req_addr       <= '0;
            req_write      <= 1'b0;
            req_wdata      <= '0;
            way_q          <= '0;
            beat           <= '0;
            hit_q          <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            cpu_hit        <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state)
                IDLE: if (cpu_req_valid) begin
                    req_addr  <= cpu_addr;
                    req_write <= cpu_write;
                    req_wdata <= cpu_wdata;
                    state     <= LOOKUP;
                end
                LOOKUP: begin
                    beat <= '0;
                    if (hit) begin
                        way_q <= hit_way;
                        hit_q <= 1'b1;
                        state <= RESPOND;
                    end else begin
                        way_q         <= victim;
                        hit_q         <= 1'b0;
                        mem_req_valid <= 1'b1;
                        if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= victim_base;
                            mem_wdata <= data_q[victim][req_idx][0];
                        end else begin
                            state     <= REFILL;
                            mem_write <= 1'b0;
                            mem_addr  <= req_addr & LINE_MASK;
                        end
                    end
                end
                WRITEBACK: if (mem_req_ready) begin
                    if (last_beat) begin
                        dirty_q[req_idx][way_q] <= 1'b0;
                        state     <= REFILL;
                        beat      <= '0;
                        mem_write <= 1'b0;
                        mem_addr  <= req_addr & LINE_MASK;
                    end else begin
                        beat      <= nxt_beat;
                        mem_addr  <= mem_addr + ADDRESS_WIDTH'(4);
                        mem_wdata <= data_q[way_q][req_idx][nxt_beat];
                    end
                end
                REFILL: if (mem_req_valid) begin
                    if (mem_req_ready) mem_req_valid <= 1'b0;
                end else if (mem_rdata_valid) begin
                    beat <= nxt_beat;
                    if (last_beat) begin
                        valid_q[req_idx][way_q] <= 1'b1;
                        dirty_q[req_idx][way_q] <= 1'b0;
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    cpu_resp_valid <= 1'b1;
                    cpu_hit        <= hit_q;
                    cpu_rdata      <= req_write ? req_wdata : data_q[way_q][req_idx][req_off];
                    if (req_write) dirty_q[req_idx][way_q] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // storage arrays carry no reset; validity lives in valid_q
    always_ff @(posedge clk) begin
        if (refill_beat) data_q[way_q][req_idx][beat] <= mem_rdata;
        if (advance) tags[way_q][req_idx] <= req_tag;
        if (state == RESPOND && req_write) data_q[way_q][req_idx][req_off] <= req_wdata;
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == RESPOND && hit_q) hit_count <= hit_count + 32'd1;
            if (state == RESPOND && !hit_q) miss_count <= miss_count + 32'd1;
            if (state == WRITEBACK && mem_req_ready && last_beat) wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule
